// File: rtl/arbitro_reg_rr.sv
// -----------------------------------------------------------------------------
// arbitro_reg_rr
//   Round-robin write arbiter that owns a shared W-bit register. Each clock it
//   picks one requester and loads that requester's data. A requester can lock
//   the register for consecutive writes. After MAX_LOCK locked grants the lock
//   is released so that other requesters are not starved.
//
// Ports
//   C       in   clock, rising edge
//   R       in   asynchronous reset, active low
//   REQ     in   [N_REQ]   write request per requester
//   LOCK    in   [N_REQ]   lock request (only counts together with REQ[i])
//   DATA    in   [N_REQ*W] write data, requester i at [i*W +: W]
//   GNT     out  [N_REQ]   one-hot grant for the load made on the last edge
//   Y       out  [W]       shared register contents
//   VALID   out            Y was loaded on the last edge
//   OWNER   out  [clog2]   index of the last writer (holds while idle)
//   LOCKED  out            arbiter is in the locked state
// -----------------------------------------------------------------------------
module arbitro_reg_rr #(
  parameter int N_REQ    = 4,
  parameter int W        = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic                     C,
  input  logic                     R,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [N_REQ-1:0]         LOCK,
  input  logic [N_REQ*W-1:0]       DATA,
  output logic [N_REQ-1:0]         GNT,
  output logic [W-1:0]             Y,
  output logic                     VALID,
  output logic [$clog2(N_REQ)-1:0] OWNER,
  output logic                     LOCKED
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic {
    ARB = 1'b0,
    LCK = 1'b1
  } state_t;

  // Registered state
  state_t           r_state;
  logic [OW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [OW-1:0]    r_owner;
  logic [W-1:0]     r_y;
  logic [N_REQ-1:0] r_gnt;
  logic             r_valid;

  // Next-state values
  state_t           w_state;
  logic [OW-1:0]    w_ptr;
  logic [CW-1:0]    w_cnt;
  logic [OW-1:0]    w_owner;
  logic [W-1:0]     w_y;
  logic [N_REQ-1:0] w_gnt;
  logic             w_valid;

  // Round-robin search result
  logic             w_found;
  logic [OW-1:0]    w_win;
  logic             w_keep;

  // Scan REQ starting at r_ptr, wrapping modulo N_REQ; first set bit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && REQ[OW'((int'(r_ptr) + k) % N_REQ)]) begin
        w_found = 1'b1;
        w_win   = OW'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end

  // The lock continues only while the owner keeps both REQ and LOCK and the
  // grant count has not reached MAX_LOCK.
  assign w_keep = (r_state == LCK) && REQ[r_owner] && LOCK[r_owner] &&
                  (r_cnt != CW'(MAX_LOCK));

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state = ARB;
    w_ptr   = r_ptr;
    w_cnt   = '0;
    w_owner = r_owner;
    w_y     = r_y;
    w_gnt   = '0;
    w_valid = 1'b0;

    if (w_keep) begin
      // Locked owner is the only eligible requester; others are not queued.
      w_state        = LCK;
      w_cnt          = r_cnt + 1'b1;
      w_y            = DATA[int'(r_owner)*W +: W];
      w_gnt[r_owner] = 1'b1;
      w_valid        = 1'b1;
    end else if (w_found) begin
      // Normal arbitration, also taken on the edge that releases a lock.
      // The previous owner is last in line because r_ptr already sits past it.
      w_owner      = w_win;
      w_y          = DATA[int'(w_win)*W +: W];
      w_gnt[w_win] = 1'b1;
      w_valid      = 1'b1;
      w_ptr        = (int'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
      if (LOCK[w_win]) begin
        w_state = LCK;
        w_cnt   = CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  // NOTE: every register, including the data register Y, is cleared by the
  // asynchronous reset because downstream logic reads Y directly.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_owner <= '0;
      r_y     <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
      r_owner <= w_owner;
      r_y     <= w_y;
      r_gnt   <= w_gnt;
      r_valid <= w_valid;
    end
  end

  assign GNT    = r_gnt;
  assign Y      = r_y;
  assign VALID  = r_valid;
  assign OWNER  = r_owner;
  assign LOCKED = (r_state == LCK);

endmodule

// File: tb/tb_arbitro_reg_rr.sv
// -----------------------------------------------------------------------------
// tb_arbitro_reg_rr
//   Directed bench for arbitro_reg_rr (N_REQ=4, W=4, MAX_LOCK=8). Inputs change
//   1 ns after the rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_arbitro_reg_rr;

  logic        C;
  logic        R;
  logic [3:0]  REQ;
  logic [3:0]  LOCK;
  logic [15:0] DATA;
  logic [3:0]  GNT;
  logic [3:0]  Y;
  logic        VALID;
  logic [1:0]  OWNER;
  logic        LOCKED;

  int n_vec;
  int n_fail;

  arbitro_reg_rr #(
    .N_REQ    (4),
    .W        (4),
    .MAX_LOCK (8)
  ) dut (
    .C      (C),
    .R      (R),
    .REQ    (REQ),
    .LOCK   (LOCK),
    .DATA   (DATA),
    .GNT    (GNT),
    .Y      (Y),
    .VALID  (VALID),
    .OWNER  (OWNER),
    .LOCKED (LOCKED)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] gnt, input logic [3:0] y,
                           input logic valid, input logic [1:0] owner, input logic locked);
    check({tag, ".gnt"},    32'(GNT),    32'(gnt));
    check({tag, ".y"},      32'(Y),      32'(y));
    check({tag, ".valid"},  32'(VALID),  32'(valid));
    check({tag, ".owner"},  32'(OWNER),  32'(owner));
    check({tag, ".locked"}, 32'(LOCKED), 32'(locked));
  endtask

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    R      = 1'b0;
    REQ    = '0;
    LOCK   = '0;
    DATA   = '0;

    // Reset state
    #2;
    check_out("reset", 4'b0000, 4'h0, 1'b0, 2'd0, 1'b0);
    #10 R = 1'b1;

    // Idle for 3 cycles
    for (int k = 0; k < 3; k++) begin
      tick;
      check_out("idle", 4'b0000, 4'h0, 1'b0, 2'd0, 1'b0);
    end

    // Full round-robin rotation, no lock
    REQ  = 4'b1111;
    DATA = 16'hDCBA;
    for (int k = 0; k < 5; k++) begin
      tick;
      check_out("rr", 4'(1 << (k % 4)), 4'(4'hA + (k % 4)), 1'b1, 2'(k % 4), 1'b0);
    end

    // Asynchronous reset in mid-cycle, no clock edge
    #3 R = 1'b0;
    #1;
    check_out("async_rst", 4'b0000, 4'h0, 1'b0, 2'd0, 1'b0);
    REQ = '0;
    #3 R = 1'b1;
    tick;
    check_out("post_rst", 4'b0000, 4'h0, 1'b0, 2'd0, 1'b0);

    // Pointer wrap: get PTR to 2, then REQ=0011 must grant requester 0
    REQ = 4'b0010;
    tick;
    check_out("ptr2", 4'b0010, 4'hB, 1'b1, 2'd1, 1'b0);
    REQ = 4'b0011;
    tick;
    check_out("wrap", 4'b0001, 4'hA, 1'b1, 2'd0, 1'b0);
    tick;
    check_out("after_wrap", 4'b0010, 4'hB, 1'b1, 2'd1, 1'b0);

    // Idle edge: Y and OWNER hold, GNT/VALID clear
    REQ = 4'b0000;
    tick;
    check_out("hold", 4'b0000, 4'hB, 1'b0, 2'd1, 1'b0);

    // Move PTR to 1
    REQ = 4'b0001;
    tick;
    check_out("ptr1", 4'b0001, 4'hA, 1'b1, 2'd0, 1'b0);

    // Lock by requester 1 up to MAX_LOCK, then forced release to requester 0.
    // LOCK[3] without REQ[3] must be ignored.
    DATA = 16'hDC5A;
    REQ  = 4'b0011;
    LOCK = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      tick;
      check_out("lock", 4'b0010, 4'h5, 1'b1, 2'd1, 1'b1);
      check("lock.cnt", 32'(dut.r_cnt), 32'(k + 1));
    end
    tick;
    check_out("forced", 4'b0001, 4'hA, 1'b1, 2'd0, 1'b0);

    // Lock dropped after 3 grants: requester 0 wins on that same edge
    LOCK = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick;
      check_out("lock2", 4'b0010, 4'h5, 1'b1, 2'd1, 1'b1);
    end
    LOCK = 4'b1000;
    tick;
    check_out("drop", 4'b0001, 4'hA, 1'b1, 2'd0, 1'b0);

    // Single requester 2 locked continuously: re-lock on every forced release
    REQ  = 4'b0100;
    LOCK = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      DATA[11:8] = 4'(k);
      tick;
      check_out("solo", 4'b0100, 4'(k), 1'b1, 2'd2, 1'b1);
      check("solo.cnt", 32'(dut.r_cnt), 32'((k % 8) + 1));
    end

    // Requester drops REQ: next edge is idle, Y holds last write
    REQ  = 4'b0000;
    LOCK = 4'b0000;
    tick;
    check_out("release_idle", 4'b0000, 4'h3, 1'b0, 2'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
